// File: rtl/alt_sng_pkg.sv
// Shared constants for the alternating stop-and-go generator: default maximal-length taps,
// default seed, LFSR width limit and seed_sel encoding.
package alt_sng_pkg;

  localparam int unsigned MAX_LFSR_W = 32;

  localparam logic [1:0] SEL_L1 = 2'd0;
  localparam logic [1:0] SEL_L2 = 2'd1;
  localparam logic [1:0] SEL_L3 = 2'd2;

  localparam logic [MAX_LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

  // Maximal-length feedback masks; bit i set feeds state bit i into the XOR.
  function automatic logic [MAX_LFSR_W-1:0] default_taps(input int unsigned w);
    logic [MAX_LFSR_W-1:0] t;
    case (w)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alt_sng_gen_lfsr_step.sv
// Fibonacci LFSR with clock enable and parallel load; shifts toward the MSB, which is the output.
module lfsr_step
  import alt_sng_pkg::*;
#(
  parameter int unsigned            W    = 11,
  parameter logic [MAX_LFSR_W-1:0] TAPS = 32'h0000_0500,
  parameter logic [MAX_LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] Mask = TAPS[W-1:0];

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = {state_q[W-2:0], ^(state_q & Mask)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED[W-1:0];
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/alt_sng_gen.sv
// Alternating stop-and-go generator: LFSR1 enables LFSR2 or LFSR3, output bits packed LSB-first.
// Optional all-zero lockup recovery is enabled by defining ALT_SNG_LOCKUP_DET_EN.
module alt_sng_gen
  import alt_sng_pkg::*;
#(
  parameter int unsigned            W1    = 11,
  parameter int unsigned            W2    = 13,
  parameter int unsigned            W3    = 17,
  parameter logic [MAX_LFSR_W-1:0] TAPS1 = default_taps(W1),
  parameter logic [MAX_LFSR_W-1:0] TAPS2 = default_taps(W2),
  parameter logic [MAX_LFSR_W-1:0] TAPS3 = default_taps(W3),
  parameter logic [MAX_LFSR_W-1:0] SEED1 = DEFAULT_SEED,
  parameter logic [MAX_LFSR_W-1:0] SEED2 = DEFAULT_SEED,
  parameter logic [MAX_LFSR_W-1:0] SEED3 = DEFAULT_SEED,
  parameter int unsigned            OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_we,
  input  logic [1:0]       seed_sel,
  input  logic [31:0]      seed_data,
  output logic             bit_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup
);

  localparam int unsigned    CntW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(OUT_W - 1);

  logic [W1-1:0] s1;
  logic [W2-1:0] s2;
  logic [W3-1:0] s3;

  logic hit1, hit2, hit3, seed_hit;
  logic zero1, zero2, zero3, any_zero;
  logic stall, step, ctl;
  logic unused_seed_bits;

  logic [OUT_W-1:0] acc_q, acc_d, data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;

  assign hit1     = seed_we & (seed_sel == SEL_L1);
  assign hit2     = seed_we & (seed_sel == SEL_L2);
  assign hit3     = seed_we & (seed_sel == SEL_L3);
  assign seed_hit = hit1 | hit2 | hit3;

`ifdef ALT_SNG_LOCKUP_DET_EN
  logic lock_q;

  assign zero1 = (s1 == '0);
  assign zero2 = (s2 == '0);
  assign zero3 = (s3 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_q | any_zero;
    end
  end

  assign lockup = lock_q;
`else
  assign zero1  = 1'b0;
  assign zero2  = 1'b0;
  assign zero3  = 1'b0;
  assign lockup = 1'b0;
`endif

  assign any_zero = zero1 | zero2 | zero3;

  // Only block a step that would complete a word on top of one still waiting.
  assign stall = valid_q & ~out_ready & (cnt_q == CntLast);
  assign step  = en & ~stall & ~seed_hit & ~any_zero;
  assign ctl   = s1[W1-1];

  assign unused_seed_bits = ^seed_data;

  lfsr_step #(.W(W1), .TAPS(TAPS1), .SEED(SEED1)) u_lfsr1 (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .load     (hit1 | zero1),
    .load_val (hit1 ? seed_data[W1-1:0] : SEED1[W1-1:0]),
    .state    (s1)
  );

  lfsr_step #(.W(W2), .TAPS(TAPS2), .SEED(SEED2)) u_lfsr2 (
    .clk      (clk),
    .rst      (rst),
    .step     (step & ctl),
    .load     (hit2 | zero2),
    .load_val (hit2 ? seed_data[W2-1:0] : SEED2[W2-1:0]),
    .state    (s2)
  );

  lfsr_step #(.W(W3), .TAPS(TAPS3), .SEED(SEED3)) u_lfsr3 (
    .clk      (clk),
    .rst      (rst),
    .step     (step & ~ctl),
    .load     (hit3 | zero3),
    .load_val (hit3 ? seed_data[W3-1:0] : SEED3[W3-1:0]),
    .state    (s3)
  );

  assign bit_out = s2[W2-1] ^ s3[W3-1];

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (seed_hit) begin
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q & out_ready) begin
        valid_d = 1'b0;
      end
      if (step) begin
        acc_d[cnt_q] = bit_out;
        if (cnt_q == CntLast) begin
          cnt_d             = '0;
          data_d            = acc_q;
          data_d[OUT_W-1]   = bit_out;
          valid_d           = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_alt_sng_gen.sv
// Self-checking bench for alt_sng_gen: vector table, directed corner sequences, random traffic.
module tb_alt_sng_gen;

  localparam int unsigned OUT_W = 8;
  localparam int unsigned W1 = 11, W2 = 13, W3 = 17;
  localparam int unsigned T1 = 32'h500, T2 = 32'h100D, T3 = 32'h12000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, seed_we = 1'b0, out_ready = 1'b0;
  logic [1:0]  seed_sel = 2'd0;
  logic [31:0] seed_data = 32'd0;
  logic        bit_out, out_valid, lockup;
  logic [7:0]  out_data;

  logic        en3 = 1'b0;
  logic        unused_b3, unused_v3, unused_l3;
  logic [3:0]  unused_d3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alt_sng_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_we   (seed_we),
    .seed_sel  (seed_sel),
    .seed_data (seed_data),
    .bit_out   (bit_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lockup    (lockup)
  );

  alt_sng_gen #(
    .W1(3), .W2(3), .W3(3),
    .TAPS1(32'h6), .TAPS2(32'h6), .TAPS3(32'h6),
    .SEED1(32'h1), .SEED2(32'h1), .SEED3(32'h1),
    .OUT_W(4)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en3),
    .seed_we   (1'b0),
    .seed_sel  (2'd0),
    .seed_data (32'd0),
    .bit_out   (unused_b3),
    .out_valid (unused_v3),
    .out_ready (1'b1),
    .out_data  (unused_d3),
    .lockup    (unused_l3)
  );

  // Reference model: LFSR states as integers, pending bits as a queue.
  int unsigned m1, m2, m3;
  bit          pend[$];
  bit          mvalid;
  logic [7:0]  mdata;
  bit          mlock;

  function automatic int unsigned wmask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int unsigned nxt(input int unsigned s, input int unsigned t,
                                      input int unsigned w);
    int unsigned fb;
    fb = $countones(s & t) % 2;
    return ((s << 1) | fb) & wmask(w);
  endfunction

  function automatic bit msb(input int unsigned s, input int unsigned w);
    return bit'((s >> (w - 1)) & 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hit, zero, stl, stp, acc, b, c;
    if (rst) begin
      m1 = 1; m2 = 1; m3 = 1;
      pend.delete();
      mvalid = 0; mdata = 0; mlock = 0;
    end else begin
      hit  = seed_we && (seed_sel != 2'd3);
      zero = 0;
`ifdef ALT_SNG_LOCKUP_DET_EN
      zero = (m1 == 0) || (m2 == 0) || (m3 == 0);
`endif
      stl = mvalid && !out_ready && (pend.size() == OUT_W - 1);
      stp = en && !stl && !hit && !zero;
      acc = mvalid && out_ready;
      if (zero) begin
        if (m1 == 0) m1 = 1;
        if (m2 == 0) m2 = 1;
        if (m3 == 0) m3 = 1;
        mlock = 1;
      end
      if (hit) begin
        case (seed_sel)
          2'd0:    m1 = seed_data & wmask(W1);
          2'd1:    m2 = seed_data & wmask(W2);
          default: m3 = seed_data & wmask(W3);
        endcase
        pend.delete();
        mvalid = 0;
      end else if (stp) begin
        b = msb(m2, W2) ^ msb(m3, W3);
        c = msb(m1, W1);
        m1 = nxt(m1, T1, W1);
        if (c) m2 = nxt(m2, T2, W2);
        else   m3 = nxt(m3, T3, W3);
        pend.push_back(b);
        if (pend.size() == OUT_W) begin
          mdata = 0;
          foreach (pend[i]) mdata[i] = pend[i];
          pend.delete();
          mvalid = 1;
        end else if (acc) begin
          mvalid = 0;
        end
      end else if (acc) begin
        mvalid = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(mvalid));
    check("out_data", 32'(out_data), 32'(mdata));
    check("bit_out", 32'(bit_out), 32'(msb(m2, W2) ^ msb(m3, W3)));
    check("lockup", 32'(lockup), 32'(mlock));
    check("s1", 32'(dut.s1), m1);
    check("s2", 32'(dut.s2), m2);
    check("s3", 32'(dut.s3), m3);
    check("cnt", 32'(dut.cnt_q), pend.size());
  endtask

  task automatic cycle(input bit r, input bit e, input bit w, input bit [1:0] sl,
                       input bit [31:0] d, input bit rd);
    rst = r; en = e; seed_we = w; seed_sel = sl; seed_data = d; out_ready = rd;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit        en;
    bit        we;
    bit [1:0]  sel;
    bit [31:0] data;
    bit        rdy;
    bit        exp_v;
    int        exp_cnt;
    bit        chk_s2;
    bit [31:0] exp_s2;
  } vec_t;

  function automatic vec_t mk(input bit e, input bit w, input bit [1:0] sl, input bit [31:0] d,
                              input bit rd, input bit v, input int cn, input bit cs,
                              input bit [31:0] s2v);
    vec_t x;
    x.en = e; x.we = w; x.sel = sl; x.data = d; x.rdy = rd;
    x.exp_v = v; x.exp_cnt = cn; x.chk_s2 = cs; x.exp_s2 = s2v;
    return x;
  endfunction

  vec_t tbl[18];

  initial begin
    int unsigned t1, t2, t3, p2, p3, chg, frz, saved_m2;
    logic [7:0]  saved;
    bit          c;

    for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 0, 1, 0, i + 1, 0, 0);
    tbl[5]  = mk(1, 1, 2'd1, 32'h0ABC, 1, 0, 0, 1, 32'h0ABC);
    tbl[6]  = mk(1, 1, 2'd3, 32'h0, 1, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 8; i < 14; i++) tbl[i] = mk(1, 0, 0, 0, 1, 0, i - 6, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 1, 0, 2, 0, 0);

    // Reset state
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_s1", 32'(dut.s1), 1);

    // Small 3-bit generator: LFSR1 period 7, exactly one of LFSR2/LFSR3 moves per step
    t1 = 1; t2 = 1; t3 = 1; chg = 0;
    en3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      p2 = 32'(dut3.s2); p3 = 32'(dut3.s3);
      c = msb(t1, 3);
      t1 = nxt(t1, 6, 3);
      if (c) t2 = nxt(t2, 6, 3);
      else   t3 = nxt(t3, 6, 3);
      cycle(0, 0, 0, 0, 0, 1);
      check("w3_s1", 32'(dut3.s1), t1);
      check("w3_s2", 32'(dut3.s2), t2);
      check("w3_s3", 32'(dut3.s3), t3);
      if (32'(dut3.s2) != p2) chg++;
      if (32'(dut3.s3) != p3) chg++;
    end
    en3 = 1'b0;
    check("w3_s1_period", 32'(dut3.s1), 1);
    check("w3_step_total", chg, 7);

    // First word timing and steady throughput
    cycle(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 24; k++) begin
      cycle(0, 1, 0, 0, 0, 1);
      check("valid_timing", 32'(out_valid), 32'((k % 8) == 0));
    end

    // Backpressure: out_data held, cnt parks at OUT_W-1, LFSRs frozen
    saved = mdata;
    frz = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(0, 1, 0, 0, 0, 0);
      check("bp_data_stable", 32'(out_data), 32'(saved));
      if (k == 8) frz = m1;
    end
    check("bp_cnt_park", 32'(dut.cnt_q), 7);
    check("bp_s1_frozen", 32'(dut.s1), frz);
    cycle(0, 1, 0, 0, 0, 1);
    check("bp_release_valid", 32'(out_valid), 1);

    // Vector table: seed write mid-word, ignored seed_sel, en low, handshake with en low
    cycle(1, 0, 0, 0, 0, 1);
    foreach (tbl[i]) begin
      cycle(0, tbl[i].en, tbl[i].we, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      check("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_v));
      check("tbl_cnt", 32'(dut.cnt_q), tbl[i].exp_cnt);
      if (tbl[i].chk_s2) check("tbl_s2_seed", 32'(dut.s2), tbl[i].exp_s2);
    end

    // All-zero LFSR1
    cycle(0, 1, 1, 2'd0, 32'h0, 1);
    saved_m2 = m2;
`ifdef ALT_SNG_LOCKUP_DET_EN
    cycle(0, 1, 0, 0, 0, 1);
    check("lock_reload_s1", 32'(dut.s1), 1);
    check("lock_set", 32'(lockup), 1);
    for (int k = 0; k < 100; k++) cycle(0, 1, 0, 0, 0, 1);
    check("lock_sticky", 32'(lockup), 1);
`else
    for (int k = 0; k < 20; k++) cycle(0, 1, 0, 0, 0, 1);
    check("zero_s1_stuck", 32'(dut.s1), 0);
    check("zero_lockup_tied", 32'(lockup), 0);
    check("zero_s2_held", 32'(dut.s2), saved_m2);
`endif

    // Reset while a word waits unaccepted
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) cycle(0, 1, 0, 0, 0, 0);
    check("pre_rst_valid", 32'(out_valid), 1);
    cycle(1, 1, 1, 2'd1, 32'h55, 0);
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_data", 32'(out_data), 0);
    check("rst_mid_s1", 32'(dut.s1), 1);
    check("rst_mid_s2", 32'(dut.s2), 1);
    check("rst_mid_s3", 32'(dut.s3), 1);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 32) == 0,
            2'($urandom % 4), (($urandom % 16) == 0) ? 32'h0 : $urandom,
            ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
